// File: rtl/frame_scanout.sv
// frame_scanout: walks a frame in raster order, issues credit-limited memory reads
// and streams the returned pixels with line/frame markers over valid/ready.
module frame_scanout #(
  parameter int Pixels_Line = 240,
  parameter int Lines_Frame = 160,
  parameter int Rd_Latency  = 2,
  parameter int Fifo_Depth  = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  output logic        oDone,
  output logic [15:0] oAdr,
  output logic        oRdEn,
  input  logic [7:0]  iRdData,
  output logic [7:0]  oPixel,
  output logic        oValid,
  input  logic        iReady,
  output logic        oSol,
  output logic        oEol,
  output logic        oSof
);
  localparam int PW = $clog2(Fifo_Depth);
  localparam int CW = $clog2(Fifo_Depth + 1);
  localparam logic [15:0] X_LAST = 16'(Pixels_Line - 1);
  localparam logic [15:0] Y_LAST = 16'(Lines_Frame - 1);
  localparam logic [PW-1:0] P_LAST = PW'(Fifo_Depth - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_x, r_y, r_adr;
  logic [2:0]      r_iflg;
  logic [Rd_Latency-1:0] r_vld;
  logic [2:0]      r_flg [Rd_Latency];
  logic [10:0]     r_mem [Fifo_Depth];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      w_infl, w_used;
  logic            w_issue, w_last, w_push, w_pop;
  logic [10:0]     w_head;

  // reads on the bus or in the return pipe, all of which will land in the buffer
  always_comb begin
    w_infl = 8'(oRdEn);
    for (int i = 0; i < Rd_Latency; i++) w_infl = w_infl + 8'(r_vld[i]);
  end

  assign w_pop   = oValid & iReady;
  assign w_push  = r_vld[Rd_Latency-1];
  assign w_used  = w_infl + 8'(r_cnt) - 8'(w_pop);
  assign w_issue = (r_state == S_SCAN) && (w_used < 8'(Fifo_Depth));
  assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_head  = r_mem[r_rp];

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == S_IDLE && iStart) ? S_SCAN :
                  (r_state == S_SCAN && w_issue && w_last) ? S_DRAIN :
                  (r_state == S_DRAIN && w_infl == 8'd0 && r_cnt == '0) ? S_IDLE : r_state;
  end

  assign oDone  = (r_state == S_IDLE);
  assign oValid = (r_cnt != '0);
  assign oPixel = oValid ? w_head[7:0] : 8'd0;
  assign oSol   = oValid & w_head[10];
  assign oEol   = oValid & w_head[9];
  assign oSof   = oValid & w_head[8];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_adr   <= '0;
      oAdr    <= '0;
      oRdEn   <= 1'b0;
      r_iflg  <= '0;
      r_vld   <= '0;
      for (int i = 0; i < Rd_Latency; i++) r_flg[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      oRdEn    <= w_issue;
      r_vld[0] <= oRdEn;
      r_flg[0] <= r_iflg;
      for (int i = 1; i < Rd_Latency; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_flg[i] <= r_flg[i-1];
      end
      if (r_state == S_IDLE && iStart) begin
        r_x   <= '0;
        r_y   <= '0;
        r_adr <= '0;
      end else if (w_issue) begin
        oAdr   <= r_adr;
        r_iflg <= {r_x == '0, r_x == X_LAST, r_x == '0 && r_y == '0};
        r_x    <= (r_x == X_LAST) ? '0 : r_x + 16'd1;
        r_y    <= (r_x != X_LAST) ? r_y : w_last ? '0 : r_y + 16'd1;
        r_adr  <= w_last ? '0 : r_adr + 16'd1;
      end
      if (w_push) r_wp <= (r_wp == P_LAST) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= (r_rp == P_LAST) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge iClk) begin
    if (w_push) r_mem[r_wp] <= {r_flg[Rd_Latency-1], iRdData};
  end
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: three DUT configurations run concurrently, each checked every
// cycle against a raster-order reference model of the pixel stream.
module tb_frame_scanout;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit f0 = 0, f1 = 0, f2 = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : c
    localparam int PL  = (g == 2) ? 240 : 4;
    localparam int LF  = (g == 2) ? 160 : 3;
    localparam int RL  = (g == 1) ? 4 : 2;
    localparam int FD  = (g == 1) ? 5 : 4;
    localparam int TOT = PL * LF;

    logic rst_n, start, ready;
    logic [7:0] seed = 8'd0;
    logic done, rden, valid, sol, eol, sof;
    logic [15:0] adr;
    logic [7:0] rd_data, pixel;
    logic [7:0] pipe [RL];

    frame_scanout #(.Pixels_Line(PL), .Lines_Frame(LF), .Rd_Latency(RL), .Fifo_Depth(FD)) dut (
      .iClk(clk), .iRst_n(rst_n), .iStart(start), .oDone(done), .oAdr(adr), .oRdEn(rden),
      .iRdData(rd_data), .oPixel(pixel), .oValid(valid), .iReady(ready),
      .oSol(sol), .oEol(eol), .oSof(sof));

    // memory: data = low address byte ^ seed, garbage on cycles without a matching read
    always @(posedge clk) begin
      pipe[0] <= rden ? (adr[7:0] ^ seed) : 8'($urandom);
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RL-1];

    int n_iss = 0, n_xfer = 0, cnt_done = 0, cyc = 0;
    int first_rden = -1, last_rden = -1, first_valid = -1, last_adr = -1;
    bit busy = 0, p_hold = 0;
    logic [10:0] p_out;

    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        chk($sformatf("c%0d rst_done", g), done, 1);
        chk($sformatf("c%0d rst_rden", g), rden, 0);
        chk($sformatf("c%0d rst_adr", g), adr, 0);
        chk($sformatf("c%0d rst_valid", g), valid, 0);
        chk($sformatf("c%0d rst_pixel", g), {pixel, sol, eol, sof}, 0);
        busy = 0; n_iss = 0; n_xfer = 0; cnt_done = 0; p_hold = 0;
      end else begin
        chk($sformatf("c%0d done", g), done, !busy);
        if (rden) begin
          chk($sformatf("c%0d rden_allowed", g), busy && n_iss < TOT, 1);
          chk($sformatf("c%0d adr", g), adr, n_iss);
          last_adr = adr;
          n_iss++;
          chk($sformatf("c%0d credit", g), n_iss - n_xfer <= FD, 1);
          if (first_rden < 0) first_rden = cyc;
          last_rden = cyc;
        end
        if (p_hold) begin
          chk($sformatf("c%0d hold_valid", g), valid, 1);
          chk($sformatf("c%0d hold_data", g), {pixel, sol, eol, sof}, p_out);
        end
        if (valid) begin
          chk($sformatf("c%0d valid_allowed", g), busy && n_xfer < TOT, 1);
          chk($sformatf("c%0d pixel", g), pixel, 8'(n_xfer) ^ seed);
          chk($sformatf("c%0d flags", g), {sol, eol, sof},
              {n_xfer % PL == 0, n_xfer % PL == PL - 1, n_xfer == 0});
          if (first_valid < 0) first_valid = cyc;
        end
        p_hold = valid && !ready;
        p_out = {pixel, sol, eol, sof};
        if (start && !busy) begin
          busy = 1; n_iss = 0; n_xfer = 0; first_rden = -1; first_valid = -1;
        end
        if (cnt_done > 0) begin
          cnt_done--;
          if (cnt_done == 0) busy = 0;
        end
        if (valid && ready) begin
          n_xfer++;
          if (n_xfer == TOT) cnt_done = 1;
        end
      end
    end
  end

  // small frames, latency 2, depth 4: directed scenarios then random backpressure
  initial begin
    int k;
    c[0].rst_n = 0; c[0].start = 0; c[0].ready = 1;
    step(2); c[0].rst_n = 1; step(1);
    c[0].start = 1; step(1); c[0].start = 0;
    k = 0; while (!c[0].done && k < 200) begin step(1); k++; end
    chk("t1_done", c[0].done, 1);
    chk("t1_issued", c[0].n_iss, 12);
    chk("t1_rden_span", c[0].last_rden - c[0].first_rden, 11);
    chk("t1_latency", c[0].first_valid - c[0].first_rden, 3);
    chk("t1_xfers", c[0].n_xfer, 12);
    c[0].ready = 0; c[0].start = 1; step(1); c[0].start = 0;
    step(20);
    chk("t2_issued", c[0].n_iss, 4);
    chk("t2_valid", c[0].valid, 1);
    chk("t2_pixel", c[0].pixel, 0);
    c[0].ready = 1;
    k = 0; while (!c[0].done && k < 200) begin step(1); k++; end
    chk("t2_done", c[0].done, 1);
    chk("t2_xfers", c[0].n_xfer, 12);
    c[0].seed = 8'h5a; c[0].start = 1; step(1); c[0].start = 0;
    k = 0; while (c[0].n_xfer < 5 && k < 200) begin step(1); k++; end
    c[0].start = 1; step(1); c[0].start = 0;
    k = 0; while (!c[0].done && k < 200) begin step(1); k++; end
    step(10);
    chk("t4_done", c[0].done, 1);
    chk("t4_xfers", c[0].n_xfer, 12);
    c[0].seed = 8'h00; c[0].start = 1; step(1); c[0].start = 0;
    step(4);
    c[0].rst_n = 0; #1;
    chk("t5_done_async", c[0].done, 1);
    chk("t5_valid_async", c[0].valid, 0);
    chk("t5_rden_async", c[0].rden, 0);
    step(1); c[0].rst_n = 1;
    step(10);
    chk("t5_no_valid", c[0].valid, 0);
    chk("t5_idle", c[0].done, 1);
    c[0].start = 1; step(1); c[0].start = 0;
    k = 0; while (!c[0].done && k < 200) begin step(1); k++; end
    chk("t5_xfers", c[0].n_xfer, 12);
    for (int f = 0; f < 4; f++) begin
      c[0].seed = 8'($urandom); c[0].start = 1; step(1); c[0].start = 0;
      k = 0;
      while (!c[0].done && k < 500) begin c[0].ready = ($urandom_range(0, 3) != 0); step(1); k++; end
      c[0].ready = 1;
      chk("c0_rand_xfers", c[0].n_xfer, 12);
    end
    f0 = 1;
  end

  // latency 4, depth 5: alternating ready, then random backpressure
  initial begin
    int k;
    c[1].rst_n = 0; c[1].start = 0; c[1].ready = 1;
    step(2); c[1].rst_n = 1; step(1);
    c[1].start = 1; step(1); c[1].start = 0;
    k = 0; while (!c[1].done && k < 300) begin c[1].ready = ~c[1].ready; step(1); k++; end
    c[1].ready = 1;
    chk("t3_done", c[1].done, 1);
    chk("t3_xfers", c[1].n_xfer, 12);
    chk("t3_issued", c[1].n_iss, 12);
    for (int f = 0; f < 4; f++) begin
      c[1].seed = 8'($urandom); c[1].start = 1; step(1); c[1].start = 0;
      k = 0;
      while (!c[1].done && k < 500) begin c[1].ready = ($urandom_range(0, 2) != 0); step(1); k++; end
      c[1].ready = 1;
      chk("c1_rand_xfers", c[1].n_xfer, 12);
    end
    f1 = 1;
  end

  // default geometry, full frame at full rate
  initial begin
    int k;
    c[2].rst_n = 0; c[2].start = 0; c[2].ready = 1;
    step(2); c[2].rst_n = 1; step(1);
    c[2].start = 1; step(1); c[2].start = 0;
    k = 0; while (!c[2].done && k < 45000) begin step(1); k++; end
    chk("t6_done", c[2].done, 1);
    chk("t6_last_adr", c[2].last_adr, 38399);
    chk("t6_xfers", c[2].n_xfer, 38400);
    f2 = 1;
  end

  initial begin
    int k = 0;
    while (!(f0 && f1 && f2) && k < 90000) begin @(posedge clk); k++; end
    if (!(f0 && f1 && f2)) chk("global_timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
Reader side of the frame buffer that the line rasteriser writes into. On a start pulse it walks every pixel of the frame in raster order and issues reads to the frame memory using the rasteriser's address mapping. It accepts read data after a fixed memory latency and presents pixels on a valid/ready stream with line and frame markers, for the display/serialiser downstream.

Parameters:
Pixels_Line, 240, pixels per line; X counts 0..Pixels_Line-1.
Lines_Frame, 160, lines per frame; Y counts 0..Lines_Frame-1.
Rd_Latency, 2, cycles from oRdEn asserted to the matching iRdData being valid; legal range 1..4.
Fifo_Depth, 4, output buffer entries; must be >= Rd_Latency+1.

Ports:
iClk  in  1  clock, all logic on rising edge.
iRst_n  in  1  asynchronous active-low reset.
iStart  in  1  one-cycle request to scan a frame.
oDone  out  1  high when idle; low from the cycle after an accepted iStart until the last pixel is handed off.
oAdr  out  16  frame memory read address = X + Y*Pixels_Line.
oRdEn  out  1  read strobe, one pixel per asserted cycle.
iRdData  in  8  pixel data, valid exactly Rd_Latency cycles after the matching oRdEn.
oPixel  out  8  pixel at head of output buffer.
oValid  out  1  oPixel valid.
iReady  in  1  downstream accepts oPixel this cycle when oValid is high.
oSol  out  1  qualifies oPixel: first pixel of a line (X==0).
oEol  out  1  qualifies oPixel: last pixel of a line (X==Pixels_Line-1).
oSof  out  1  qualifies oPixel: first pixel of frame (X==0, Y==0).

Behaviour:
- Reset values: oDone=1, oRdEn=0, oAdr=0, oValid=0, oPixel=0, oSol=oEol=oSof=0. The state is IDLE, the counters are 0, the buffer is empty, and the in-flight pipeline is cleared.
- States:
  - IDLE -> SCAN on iStart. This clears X and Y and sets oDone=0.
  - SCAN -> DRAIN in the cycle the read of (Pixels_Line-1, Lines_Frame-1) issues.
  - DRAIN -> IDLE when no read is in flight and the buffer is empty. oDone rises in that cycle, registered, and is visible the next cycle.
- iStart outside IDLE is ignored with no effect.
- Read issue:
  - oRdEn is asserted in SCAN only when (in-flight reads + buffer occupancy) < Fifo_Depth. This credit rule guarantees that returning data never overflows the buffer.
  - oAdr and oRdEn are registered together.
  - X increments after each issue. At Pixels_Line-1, X wraps to 0 and Y increments.
  - Address arithmetic is at least 16 bits. No truncation is allowed for the default parameters (max 38399).
- Return path:
  - A Rd_Latency-deep valid shift register tracks the reads, together with the sol/eol/sof flags computed at issue time.
  - When the tail is valid, iRdData and the flags are written into the buffer that cycle.
- Output:
  - oValid is high when the buffer is non-empty.
  - A transfer occurs when oValid and iReady are both high, and the head pops.
  - A simultaneous push and pop keeps the occupancy unchanged.
  - Holding iReady=0 stalls issue once credits are exhausted. There is no data loss and no duplication.
  - oPixel and the flags stay stable while oValid is high and iReady is low.
- Ordering: pixels leave in strict raster order, exactly Pixels_Line*Lines_Frame transfers per frame.
- Reset mid-operation: an immediate return to the reset values. Data returning afterwards for pre-reset reads is discarded.

Test Plan:
1. Pixels_Line=4, Lines_Frame=3, Rd_Latency=2, iReady=1, memory returns data=address. Pulse iStart:
   - oRdEn is high for 12 consecutive cycles with oAdr 0..11.
   - oPixel is 0..11 starting 3 cycles after the first oRdEn.
   - oSof is set on pixel 0; oSol on 0,4,8; oEol on 3,7,11.
   - oDone returns to 1 after pixel 11 transfers.
2. Same parameters, iReady=0 from start:
   - Exactly Fifo_Depth=4 reads issue (adr 0..3), then oRdEn stays 0.
   - oValid=1 with oPixel=0 held.
   - Releasing iReady resumes the sequence with no gaps in the data.
3. iReady toggling 1/0 every cycle, Rd_Latency=4, Fifo_Depth=5: all 12 pixels arrive in order, none duplicated, and the marker flags are correct.
4. iStart pulsed again at pixel 5 mid-scan: it is ignored; a single frame of 12 pixels is produced.
5. iRst_n asserted low for 1 cycle while reads are in flight:
   - All outputs take their reset values immediately, with oDone=1.
   - No oValid appears afterwards until a new iStart, which begins again at adr 0.
6. Default parameters, iReady=1: the final read oAdr is 38399, and exactly 38400 transfers occur before oDone rises.
